// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch-state encoding, FIFO depth and entry layout
// for the instruction fetch path.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int unsigned FETCH_DATA_WIDTH = 32;
  localparam int unsigned FETCH_ADDR_WIDTH = 10;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] instr;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry valid/ready FIFO holding returned fetch entries.
// The head register drives the output directly so it stays stable while the
// consumer stalls; flush discards everything at the next edge.
module fetch_skid_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_DATA_WIDTH + FETCH_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = head_q;
  assign count_o = count_q;

  // Next head/tail/count from push, pop and flush.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_ok})
        2'b10: begin
          if (count_q == '0) head_d = data_i;
          else               tail_d = data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = data_i;
          end else begin
            head_d = tail_q;
            tail_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: owns the fetch PC, issues reads to the synchronous
// instruction memory, absorbs its 1-cycle latency and decode stalls through
// a 2-entry FIFO, and flushes wrong-path work on redirects.
// Optional: define FETCH_HALT_ON_ZERO_EN to halt fetch on a returned zero word.
module imem_fetch_controller
  import mips_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  halted
);

  localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic [EW-1:0]         fifo_head;
  logic                  pop, push, ret_ok, halt_hit, run_ok, issue;

  assign pop    = instr_valid & instr_ready;
  assign ret_ok = inflight_q & ~redirect_valid;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halt_hit = ret_ok & (imem_data == '0);
  assign halted   = (state_q == ST_HALTED);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign push = ret_ok & ~halt_hit;

  // Issue is gated on enable directly (IDLE with enable counts as running)
  // so the first fetch goes out in the cycle reset releases, giving the
  // 2-cycle first-valid latency, and a low enable stops issue immediately.
  assign run_ok    = enable & (state_q != ST_HALTED);
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q};
  assign issue     = run_ok & ~redirect_valid & ~halt_hit &
                     (occupancy < (3'(FETCH_FIFO_DEPTH) + {2'b0, pop}));

  assign imem_addr = fetch_pc_q;
  assign instr_out = fifo_head[EW-1:ADDR_WIDTH];
  assign pc_out    = fifo_head[ADDR_WIDTH-1:0];

  fetch_skid_fifo #(
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({imem_data, inflight_pc_q}),
    .pop_i   (pop),
    .valid_o (instr_valid),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  // FSM next state, PC sequencing and inflight tracking; redirect wins.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
      if (state_q == ST_HALTED) state_d = ST_RUN;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: if (enable)  state_d = ST_RUN;
        ST_RUN:  if (!enable) state_d = ST_IDLE;
        default: ;
      endcase
      if (halt_hit) state_d = ST_HALTED;
    end
  end

  // State, PC and inflight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= ADDR_WIDTH'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_controller.sv
// tb_imem_fetch_controller: directed latency/stall/redirect/wrap/enable
// scenarios plus a randomized run checked against an in-order stream model.
module tb_imem_fetch_controller;
  import mips_fetch_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, enable, redirect_valid, instr_ready;
  logic          instr_valid, halted;
  logic [AW-1:0] imem_addr, redirect_addr, pc_out;
  logic [DW-1:0] imem_data, instr_out;
  logic [DW-1:0] mem [DEPTH];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the address.
  always_ff @(posedge clk) imem_data <= mem[imem_addr];

  imem_fetch_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Release reset at a negedge; the following posedge ends cycle 0.
  task automatic release_run();
    rst_n = 1'b1; enable = 1'b1; instr_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
    checks++; if (instr_out !== '0) begin errors++; $display("FAIL rst_instr got %0h want 0", instr_out); end
    checks++; if (pc_out !== '0) begin errors++; $display("FAIL rst_pc got %0d want 0", pc_out); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d want 0", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b want 0", halted); end
    release_run();
    for (int i = 0; i < 4; i++) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== '0 || pc_out !== '0) begin
      errors++; $display("FAIL async_rst got valid=%0b addr=%0d pc=%0d want 0/0/0", instr_valid, imem_addr, pc_out);
    end
  endtask

  task automatic test_stream();
    do_reset();
    release_run();
    for (int c = 0; c < 6; c++) begin
      if (c < 2) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_low c%0d got %0b want 0", c, instr_valid); end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== AW'(c-2) || instr_out !== mem[c-2]) begin
          errors++; $display("FAIL stream c%0d got v=%0b pc=%0d ins=%0h want 1/%0d/%0h", c, instr_valid, pc_out, instr_out, c-2, mem[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    release_run();
    tick(); tick();
    checks++; if (instr_valid !== 1'b1 || pc_out !== AW'(0)) begin errors++; $display("FAIL stall_first got v=%0b pc=%0d want 1/0", instr_valid, pc_out); end
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== AW'(0) || instr_out !== mem[0] || imem_addr !== AW'(2)) begin
        errors++; $display("FAIL stall_hold i%0d got v=%0b pc=%0d ins=%0h addr=%0d want 1/0/%0h/2", i, instr_valid, pc_out, instr_out, imem_addr, mem[0]);
      end
    end
    instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== AW'(k) || instr_out !== mem[k]) begin
        errors++; $display("FAIL stall_resume k%0d got v=%0b pc=%0d ins=%0h want 1/%0d/%0h", k, instr_valid, pc_out, instr_out, k, mem[k]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    release_run();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (pc_out !== AW'(3)) begin errors++; $display("FAIL redir_pre got pc=%0d want 3", pc_out); end
    redirect_valid = 1'b1; redirect_addr = AW'(8);
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_t1 got v=%0b want 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_t2 got v=%0b want 0", instr_valid); end
    for (int k = 8; k <= 9; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== AW'(k) || instr_out !== mem[k]) begin
        errors++; $display("FAIL redir_tgt got v=%0b pc=%0d ins=%0h want 1/%0d/%0h", instr_valid, pc_out, instr_out, k, mem[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned want;
    redirect_valid = 1'b1; redirect_addr = AW'(1022);
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      want = (1022 + i) % DEPTH;
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== AW'(want) || instr_out !== mem[want]) begin
        errors++; $display("FAIL wrap i%0d got v=%0b pc=%0d want 1/%0d", i, instr_valid, pc_out, want);
      end
    end
  endtask

  task automatic test_enable();
    int unsigned   exp_pc;
    logic [AW-1:0] frozen;
    do_reset();
    release_run();
    for (int i = 0; i < 4; i++) tick();
    exp_pc = 2;
    frozen = '0;
    for (int c = 0; c < 40 && exp_pc < 12; c++) begin
      if (c >= 2 && c <= 4) begin
        checks++; if (imem_addr !== frozen) begin errors++; $display("FAIL en_frozen c%0d got %0d want %0d", c, imem_addr, frozen); end
      end
      if (instr_valid) begin
        checks++;
        if (pc_out !== AW'(exp_pc) || instr_out !== mem[exp_pc]) begin
          errors++; $display("FAIL en_seq got pc=%0d ins=%0h want %0d/%0h", pc_out, instr_out, exp_pc, mem[exp_pc]);
        end
        exp_pc++;
      end
      if (c == 1) begin enable = 1'b0; frozen = imem_addr; end
      if (c == 4) enable = 1'b1;
      tick();
    end
    checks++; if (exp_pc != 12) begin errors++; $display("FAIL en_timeout got %0d delivered-to want 12", exp_pc); end
  endtask

  task automatic test_random();
    int unsigned  exp_pc, xfers;
    logic         prev_stall;
    fetch_entry_t held;
    do_reset();
    release_run();
    exp_pc = 0; xfers = 0; prev_stall = 1'b0; held = '0;
    for (int c = 0; c < 1500; c++) begin
      if (prev_stall) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== held.instr || pc_out !== held.pc) begin
          errors++; $display("FAIL rnd_hold c%0d got v=%0b pc=%0d want 1/%0d", c, instr_valid, pc_out, held.pc);
        end
      end
      instr_ready    = ($urandom_range(3) != 0);
      enable         = ($urandom_range(7) != 0);
      redirect_valid = ($urandom_range(39) == 0);
      redirect_addr  = AW'($urandom_range(DEPTH-1));
      if (instr_valid && instr_ready) begin
        checks++;
        if (pc_out !== AW'(exp_pc) || instr_out !== mem[exp_pc]) begin
          errors++; $display("FAIL rnd_xfer c%0d got pc=%0d ins=%0h want %0d/%0h", c, pc_out, instr_out, exp_pc, mem[exp_pc]);
        end
        exp_pc = (exp_pc + 1) % DEPTH;
        xfers++;
      end
      if (redirect_valid) exp_pc = int'(redirect_addr);
      prev_stall = instr_valid & ~instr_ready & ~redirect_valid;
      held.instr = instr_out;
      held.pc    = pc_out;
      tick();
    end
    redirect_valid = 1'b0;
    checks++; if (xfers < 300) begin errors++; $display("FAIL rnd_progress got %0d want >=300", xfers); end
  endtask

  task automatic test_zero_word();
    int unsigned   n_del;
    logic [AW-1:0] addr0;
    mem[22] = '0;
    do_reset();
    release_run();
    redirect_valid = 1'b1; redirect_addr = AW'(20);
    tick();
    redirect_valid = 1'b0;
    n_del = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (instr_valid) begin
        checks++;
        if (pc_out !== AW'(20 + n_del) || instr_out !== mem[20 + n_del]) begin
          errors++; $display("FAIL zero_seq got pc=%0d ins=%0h want %0d/%0h", pc_out, instr_out, 20 + n_del, mem[20 + n_del]);
        end
        n_del++;
      end
    end
`ifdef FETCH_HALT_ON_ZERO_EN
    checks++; if (n_del != 2) begin errors++; $display("FAIL halt_count got %0d want 2", n_del); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0b want 1", halted); end
    addr0 = imem_addr;
    tick(); tick();
    checks++; if (imem_addr !== addr0) begin errors++; $display("FAIL halt_addr got %0d want %0d", imem_addr, addr0); end
    redirect_valid = 1'b1; redirect_addr = '0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit got %0b want 0", halted); end
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== '0 || instr_out !== mem[0]) begin
      errors++; $display("FAIL halt_resume got v=%0b pc=%0d want 1/0", instr_valid, pc_out);
    end
`else
    addr0 = '0;
    checks++; if (n_del < 3) begin errors++; $display("FAIL zero_count got %0d want >=3", n_del); end
    checks++; if (halted !== addr0[0]) begin errors++; $display("FAIL zero_halted got %0b want 0", halted); end
`endif
    mem[22] = $urandom | 32'h1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom | 32'h1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_enable();
    test_random();
    test_zero_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_controller.md
Name: imem_fetch_controller

Overview:
- Sequences the synchronous instruction memory: owns the fetch PC and drives the memory read address.
- Absorbs the memory's 1-cycle read latency and the decode stage's stalls, and delivers instruction/PC pairs with a valid/ready handshake.
- Handles redirects (jump/branch) by flushing wrong-path fetches.
- Sits between the instruction memory and the decode stage of the MIPS pipeline.

Parameters:
- ADDR_WIDTH, 10, word-address width; matches instruction memory depth of 1024 words.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, fetch PC loaded at reset.

Ports:
- clk  input  1  single clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  run control; low stops issuing new fetches.
- imem_addr  output  ADDR_WIDTH  read address to instruction memory; equals the fetch_pc register.
- imem_data  input  DATA_WIDTH  memory read data; holds the word addressed on the previous cycle.
- redirect_valid  input  1  flush the pipe and restart fetch at redirect_addr.
- redirect_addr  input  ADDR_WIDTH  new fetch target.
- instr_valid  output  1  instr_out/pc_out hold a valid entry.
- instr_ready  input  1  decode accepts; a transfer occurs when valid & ready.
- instr_out  output  DATA_WIDTH  instruction word.
- pc_out  output  ADDR_WIDTH  word address of instr_out.
- halted  output  1  fetch halted (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, imem_addr=RESET_PC, FIFO empty, inflight=0, instr_valid=0, instr_out=0, pc_out=0, halted=0, state=IDLE.
- Internal storage:
  - 2-entry FIFO of {instr, pc}; the head drives instr_out/pc_out.
  - inflight flag plus inflight_pc.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0.
  - RUN/IDLE -> HALTED only with the macro.
  - HALTED -> RUN on redirect_valid.
- Issue condition: state=RUN & !redirect_valid & (fifo_count + inflight - pop) < 2, where pop = instr_valid & instr_ready.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^ADDR_WIDTH (1023 -> 0).
  - No issue: inflight<=0.
- Return: when inflight=1, push {imem_data, inflight_pc} into the FIFO on the next edge, unless flushed.
- Push and pop may occur in the same cycle; fifo_count is unchanged. The FIFO never overflows, by the issue condition.
- Latency:
  - Fetch issued in cycle t: data on imem_data in t+1, instr_valid in t+2.
  - From reset release with enable=1: first instr_valid at cycle 2 (0-based); then 1 instruction/cycle while instr_ready=1.
- Stall: while instr_ready=0, at most 2 entries are held. instr_out/pc_out stay stable while valid & !ready.
- Redirect (highest priority), in cycle t:
  - A transfer in t still counts if instr_ready=1.
  - At the edge: FIFO cleared, inflight data discarded, fetch_pc<=redirect_addr, halted<=0.
  - Issue at t+1; the target's instr_valid rises at t+3.
  - A redirect in IDLE also loads fetch_pc.
- enable=0 mid-operation: no new issue; inflight and buffered entries still drain normally.
- Reset mid-operation: all state returns to reset values immediately (async); an inflight word is lost.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined:
  - A returning non-flushed word equal to 0 is not pushed; state<=HALTED, halted=1.
  - Any fetch issued in the same cycle is discarded.
  - No issue in HALTED; already-buffered entries still drain.
  - Exit only via redirect_valid.
- Undefined: zero words are delivered as ordinary instructions (nop); halted tied 0; no HALTED state.

Decomposition:
- Shared package `mips_fetch_pkg`: fetch state enum (IDLE, RUN, HALTED), FIFO depth constant (2), default RESET_PC, fetch-entry struct {instr, pc}.
- One natural sub-module: `fetch_skid_fifo`, a 2-entry valid/ready FIFO with flush input. The controller owns the PC, issue logic and FSM.

Test Plan:
- Reset then enable=1, ready=1, memory words 0..3 = A,B,C,D -> instr_valid from cycle 2, outputs A@0, B@1, C@2, D@3 on consecutive cycles.
- ready=0 for 5 cycles mid-stream after A is presented -> A/pc 0 held stable, at most 2 entries buffered, imem_addr frozen; on ready=1, B,C follow with no gap or duplicate.
- redirect_valid with redirect_addr=8 at cycle t while words 4,5 are inflight/buffered -> words 4,5 never delivered; instr at pc 8 valid at t+3.
- Redirect to 1022, ready=1 -> pc_out sequence 1022, 1023, 0, 1 (wrap-around).
- enable dropped for 3 cycles, then raised -> no new imem_addr advance while low, buffered entries drain, resume at next pc with no loss.
- FETCH_HALT_ON_ZERO_EN defined, word 22 = 0 -> pc 21 is last delivered, halted=1, imem_addr frozen; redirect to 0 -> halted=0, pc 0 delivered 3 cycles later. Macro undefined -> word 0 delivered, halted=0.
